eth_rx_packet_checker: RTL and testbench

- Sits directly downstream of the 10G core's Rx AXI-Stream master (m00_axis_*).
- Consumes the looped-back test stream produced by the Tx packet generator. In that stream, data[15:0] is a per-packet beat index from 0 to L, data[63:16] is a constant payload, and tlast is set on index L.
- Checks every beat and every frame, keeps saturating good/bad/frame-error counters, and reports a lock flag plus the last error code for VIO/ILA observation.
- Has no backpressure: the Rx stream has no tready, so every tvalid beat is consumed.

---
 rtl/eth_rx_packet_checker.sv | 150 +++++++++++++++
 tb/tb_eth_rx_packet_checker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_packet_checker.sv
// Rx-side checker for the looped-back Tx generator stream: validates beat index,
// byte enables, payload and frame length, and keeps saturating frame statistics.
module eth_rx_packet_checker #(
  parameter int CNT_WIDTH = 32,
  parameter int IDX_WIDTH = 16
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_aresetn,
  input  logic [63:0]          s00_axis_tdata,
  input  logic [7:0]           s00_axis_tkeep,
  input  logic                 s00_axis_tvalid,
  input  logic                 s00_axis_tlast,
  input  logic                 s00_axis_tuser,
  input  logic [IDX_WIDTH-1:0] cfg_packet_length,
  input  logic [47:0]          cfg_payload_data,
  input  logic                 cfg_check_payload,
  input  logic                 clear_counters,
  output logic [CNT_WIDTH-1:0] good_count,
  output logic [CNT_WIDTH-1:0] bad_count,
  output logic [CNT_WIDTH-1:0] fcs_err_count,
  output logic [2:0]           last_error_code,
  output logic                 error_pulse,
  output logic                 locked
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    CHECK = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_r;
  logic [IDX_WIDTH-1:0] expected_idx_r;
  logic [IDX_WIDTH-1:0] len_q_r;
  logic [IDX_WIDTH-1:0] len_s;
  logic [2:0]           beat_code_s;
  logic                 first_err_s;
  logic                 close_s;
  logic                 close_bad_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Per-beat error classification; the first beat of a frame uses the live length.
  always_comb begin
    len_s       = (expected_idx_r == {IDX_WIDTH{1'b0}}) ? cfg_packet_length : len_q_r;
    beat_code_s = 3'd0;
    if (s00_axis_tdata[IDX_WIDTH-1:0] != expected_idx_r) begin
      beat_code_s = 3'd1;
    end else if (s00_axis_tkeep != 8'hFF) begin
      beat_code_s = 3'd2;
    end else if (cfg_check_payload && (s00_axis_tdata[63:16] != cfg_payload_data)) begin
      beat_code_s = 3'd3;
    end else if (s00_axis_tlast && (expected_idx_r < len_s)) begin
      beat_code_s = 3'd4;
    end else if (!s00_axis_tlast && (expected_idx_r == len_s)) begin
      beat_code_s = 3'd5;
    end else if (s00_axis_tlast && s00_axis_tuser) begin
      beat_code_s = 3'd6;
    end else begin
      beat_code_s = 3'd0;
    end
  end

  // Frame-level events derived from the current beat.
  always_comb begin
    first_err_s = s00_axis_tvalid && (state_r == CHECK) && (beat_code_s != 3'd0);
    close_s     = s00_axis_tvalid && s00_axis_tlast &&
                  ((state_r == CHECK) || (state_r == DRAIN));
    close_bad_s = close_s && ((state_r == DRAIN) || (beat_code_s != 3'd0));
  end

  // Frame tracking state machine, statistics and status outputs.
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state_r         <= SYNC;
      expected_idx_r  <= {IDX_WIDTH{1'b0}};
      len_q_r         <= {IDX_WIDTH{1'b0}};
      good_count      <= {CNT_WIDTH{1'b0}};
      bad_count       <= {CNT_WIDTH{1'b0}};
      fcs_err_count   <= {CNT_WIDTH{1'b0}};
      last_error_code <= 3'd0;
      error_pulse     <= 1'b0;
      locked          <= 1'b0;
    end else begin
      error_pulse <= first_err_s;

      if (s00_axis_tvalid) begin
        case (state_r)
          SYNC: begin
            if (s00_axis_tlast) begin
              state_r        <= CHECK;
              expected_idx_r <= {IDX_WIDTH{1'b0}};
            end
          end
          CHECK: begin
            if (expected_idx_r == {IDX_WIDTH{1'b0}}) begin
              len_q_r <= cfg_packet_length;
            end
            if (s00_axis_tlast) begin
              expected_idx_r <= {IDX_WIDTH{1'b0}};
            end else if (beat_code_s != 3'd0) begin
              state_r <= DRAIN;
            end else begin
              expected_idx_r <= expected_idx_r + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
            end
          end
          DRAIN: begin
            if (s00_axis_tlast) begin
              state_r        <= CHECK;
              expected_idx_r <= {IDX_WIDTH{1'b0}};
            end
          end
          default: begin
            state_r        <= SYNC;
            expected_idx_r <= {IDX_WIDTH{1'b0}};
          end
        endcase
      end

      // A clear in the same cycle as a frame close drops that frame from the stats.
      if (clear_counters) begin
        good_count      <= {CNT_WIDTH{1'b0}};
        bad_count       <= {CNT_WIDTH{1'b0}};
        fcs_err_count   <= {CNT_WIDTH{1'b0}};
        last_error_code <= 3'd0;
      end else begin
        if (close_s) begin
          if (close_bad_s) begin
            bad_count <= sat_inc(bad_count);
          end else begin
            good_count <= sat_inc(good_count);
          end
          if (s00_axis_tuser) begin
            fcs_err_count <= sat_inc(fcs_err_count);
          end
        end
        if (first_err_s) begin
          last_error_code <= beat_code_s;
        end
      end

      if (close_s) begin
        locked <= !close_bad_s;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_packet_checker.sv
// Bench for eth_rx_packet_checker: frames are built as lists of beats and judged
// whole by a frame-level reference model; a 4-bit-counter instance covers saturation.
module tb_eth_rx_packet_checker;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] tdata = 64'd0;
  logic [7:0]  tkeep = 8'hFF;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [15:0] cfg_len = 16'd3;
  logic [47:0] cfg_pay = 48'hA5A5_1234_5678;
  logic        cfg_chk = 1'b0;
  logic        clr = 1'b0;

  logic [31:0] good, bad, fcs;
  logic [2:0]  code;
  logic        pulse, locked;
  logic [3:0]  s_good, s_bad, s_fcs;
  logic [2:0]  s_code;
  logic        s_pulse, s_locked;

  int checks = 0;
  int errors = 0;

  // reference model state
  int       m_good, m_bad, m_fcs;
  logic [2:0] m_code;
  bit       m_locked, m_synced;

  // frame under construction
  logic [15:0] f_idx[$];
  logic [7:0]  f_keep[$];
  bit          f_pbad[$];
  bit          f_tuser;

  always #5 clk = ~clk;

  eth_rx_packet_checker dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(aresetn), .s00_axis_tdata(tdata),
    .s00_axis_tkeep(tkeep), .s00_axis_tvalid(tvalid), .s00_axis_tlast(tlast),
    .s00_axis_tuser(tuser), .cfg_packet_length(cfg_len), .cfg_payload_data(cfg_pay),
    .cfg_check_payload(cfg_chk), .clear_counters(clr), .good_count(good),
    .bad_count(bad), .fcs_err_count(fcs), .last_error_code(code),
    .error_pulse(pulse), .locked(locked)
  );

  eth_rx_packet_checker #(.CNT_WIDTH(4)) dut_small (
    .s00_axis_aclk(clk), .s00_axis_aresetn(aresetn), .s00_axis_tdata(tdata),
    .s00_axis_tkeep(tkeep), .s00_axis_tvalid(tvalid), .s00_axis_tlast(tlast),
    .s00_axis_tuser(tuser), .cfg_packet_length(cfg_len), .cfg_payload_data(cfg_pay),
    .cfg_check_payload(cfg_chk), .clear_counters(clr), .good_count(s_good),
    .bad_count(s_bad), .fcs_err_count(s_fcs), .last_error_code(s_code),
    .error_pulse(s_pulse), .locked(s_locked)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat4(input int v);
    sat4 = (v > 15) ? 64'd15 : 64'(v);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".good"},    64'(good),     64'(m_good));
    chk({tag, ".bad"},     64'(bad),      64'(m_bad));
    chk({tag, ".fcs"},     64'(fcs),      64'(m_fcs));
    chk({tag, ".code"},    64'(code),     64'(m_code));
    chk({tag, ".locked"},  64'(locked),   64'(m_locked));
    chk({tag, ".s_good"},  64'(s_good),   sat4(m_good));
    chk({tag, ".s_bad"},   64'(s_bad),    sat4(m_bad));
    chk({tag, ".s_fcs"},   64'(s_fcs),    sat4(m_fcs));
    chk({tag, ".s_code"},  64'(s_code),   64'(m_code));
  endtask

  task automatic build(input int n, input bit tu);
    f_idx.delete(); f_keep.delete(); f_pbad.delete();
    for (int i = 0; i < n; i++) begin
      f_idx.push_back(16'(i));
      f_keep.push_back(8'hFF);
      f_pbad.push_back(1'b0);
    end
    f_tuser = tu;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0; tvalid = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    m_good = 0; m_bad = 0; m_fcs = 0; m_code = 3'd0; m_locked = 1'b0; m_synced = 1'b0;
    check_all("reset");
    chk("reset.pulse", 64'(pulse), 64'd0);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_good = 0; m_bad = 0; m_fcs = 0; m_code = 3'd0;
    check_all("clear");
  endtask

  task automatic idle_gaps(input int maxg);
    int g;
    g = $urandom_range(0, maxg);
    for (int k = 0; k < g; k++) begin
      tvalid = 1'b0;
      tdata  = {$urandom, $urandom};
      tlast  = 1'($urandom);
      tuser  = 1'($urandom);
      @(negedge clk);
      chk("gap.pulse", 64'(pulse), 64'd0);
    end
  endtask

  // Drives the built frame; the model judges it as a whole from the frame rules.
  task automatic send_frame(input string tag, input bit clr_on_last, input int chg_len, input int maxg);
    int         n, first_err;
    logic [2:0] ecode, c;
    int         len;
    bit         last, synced_at_start;
    n = f_idx.size();
    len = int'(cfg_len);
    first_err = -1;
    ecode = 3'd0;
    synced_at_start = m_synced;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      c = 3'd0;
      if (f_idx[i] != 16'(i))                          c = 3'd1;
      else if (f_keep[i] != 8'hFF)                     c = 3'd2;
      else if (cfg_chk && f_pbad[i])                   c = 3'd3;
      else if (last && (i < len))                      c = 3'd4;
      else if (!last && (i == len))                    c = 3'd5;
      else if (last && f_tuser)                        c = 3'd6;
      if (c != 3'd0) begin
        first_err = i;
        ecode = c;
        break;
      end
    end

    for (int i = 0; i < n; i++) begin
      idle_gaps(maxg);
      tvalid = 1'b1;
      tdata  = {(f_pbad[i] ? (cfg_pay ^ 48'h0000_0100_0001) : cfg_pay), f_idx[i]};
      tkeep  = f_keep[i];
      tlast  = (i == n - 1);
      tuser  = (i == n - 1) ? f_tuser : 1'($urandom);
      clr    = clr_on_last && (i == n - 1);
      @(negedge clk);
      tvalid = 1'b0;
      clr    = 1'b0;
      if ((i == 0) && (chg_len >= 0)) cfg_len = 16'(chg_len);
      chk({tag, ".pulse"},   64'(pulse),   64'(synced_at_start && (i == first_err)));
      chk({tag, ".s_pulse"}, 64'(s_pulse), 64'(synced_at_start && (i == first_err)));
    end

    if (synced_at_start) begin
      if (first_err >= 0) begin
        m_bad++;
        m_locked = 1'b0;
        m_code = ecode;
      end else begin
        m_good++;
        m_locked = 1'b1;
      end
      if (f_tuser) m_fcs++;
    end else begin
      m_synced = 1'b1;
    end
    if (clr_on_last) begin
      m_good = 0; m_bad = 0; m_fcs = 0; m_code = 3'd0;
    end
    check_all(tag);
  endtask

  initial begin
    int mut, k, n, tmp;

    // partial frame after reset is discarded, then three good frames
    do_reset();
    cfg_len = 16'd3; cfg_chk = 1'b0;
    build(2, 1'b0); f_idx[0] = 16'd2; f_idx[1] = 16'd3;
    send_frame("sync", 1'b0, -1, 1);
    for (int i = 0; i < 3; i++) begin
      build(4, 1'b0);
      send_frame("good3", 1'b0, -1, 2);
    end
    chk("good3.const_good", 64'(good), 64'd3);
    chk("good3.const_locked", 64'(locked), 64'd1);

    // index error with payload check enabled, then a good frame
    cfg_chk = 1'b1;
    build(4, 1'b0); f_idx[2] = 16'd7;
    send_frame("idx_err", 1'b0, -1, 1);
    chk("idx_err.const_code", 64'(code), 64'd1);
    build(4, 1'b0);
    send_frame("after_idx", 1'b0, -1, 1);
    chk("after_idx.const_good", 64'(good), 64'd4);
    chk("after_idx.const_bad", 64'(bad), 64'd1);

    // short and long frames
    build(2, 1'b0);
    send_frame("short", 1'b0, -1, 1);
    chk("short.const_code", 64'(code), 64'd4);
    build(6, 1'b0);
    send_frame("long", 1'b0, -1, 1);
    chk("long.const_code", 64'(code), 64'd5);
    chk("long.const_bad", 64'(bad), 64'd3);

    // frame error flag on the tlast beat
    build(4, 1'b1);
    send_frame("tuser", 1'b0, -1, 1);
    chk("tuser.const_code", 64'(code), 64'd6);
    chk("tuser.const_fcs", 64'(fcs), 64'd1);

    // tkeep and payload errors
    build(4, 1'b0); f_keep[1] = 8'h0F;
    send_frame("keep", 1'b0, -1, 1);
    build(4, 1'b0); f_pbad[3] = 1'b1;
    send_frame("payload", 1'b0, -1, 1);
    cfg_chk = 1'b0;
    build(4, 1'b0); f_pbad[1] = 1'b1;
    send_frame("payload_off", 1'b0, -1, 1);

    // saturation of the narrow counters, then clear coincident with a frame close
    do_clear();
    for (int i = 0; i < 20; i++) begin
      build(4, 1'b0);
      send_frame("sat", 1'b0, -1, 0);
    end
    chk("sat.const_s_good", 64'(s_good), 64'd15);
    build(4, 1'b1);
    send_frame("clr_last", 1'b1, -1, 0);
    chk("clr_last.const_good", 64'(good), 64'd0);

    // single-beat frames with gaps, then a length change applied to the next frame
    cfg_len = 16'd0;
    for (int i = 0; i < 10; i++) begin
      build(1, 1'b0);
      send_frame("single", 1'b0, -1, 3);
    end
    chk("single.const_good", 64'(good), 64'd10);
    cfg_len = 16'd2;
    build(3, 1'b0);
    send_frame("len2", 1'b0, -1, 1);

    // length change during a frame does not affect that frame
    build(3, 1'b0);
    send_frame("midchg", 1'b0, 5, 1);
    build(6, 1'b0);
    send_frame("newlen", 1'b0, -1, 1);

    // reset in the middle of a frame; the resync frame is not counted
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tdata = {cfg_pay, 16'(i)}; tkeep = 8'hFF; tlast = 1'b0; tuser = 1'b0;
      @(negedge clk);
    end
    tvalid = 1'b0;
    do_reset();
    build(4, 1'b0);
    send_frame("resync", 1'b0, -1, 1);
    chk("resync.const_good", 64'(good), 64'd0);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      cfg_len = 16'($urandom_range(0, 5));
      cfg_chk = 1'($urandom);
      n = int'(cfg_len) + 1;
      mut = $urandom_range(0, 6);
      if (mut == 4 && n > 1) n = $urandom_range(1, n - 1);
      if (mut == 5) n = n + $urandom_range(1, 3);
      build(n, (mut == 6) || ((mut == 1) && ($urandom_range(0, 1) == 1)));
      k = $urandom_range(0, n - 1);
      tmp = $urandom_range(1, 255);
      case (mut)
        1: f_idx[k] = f_idx[k] ^ 16'(tmp);
        2: f_keep[k] = 8'hFF ^ 8'(tmp);
        3: f_pbad[k] = 1'b1;
        default: ;
      endcase
      send_frame("rand", ($urandom_range(0, 15) == 0), -1, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
